// File: rtl/control_pipe.sv
// control_pipe
//   Pipelined main control unit for the MIPS datapath. The opcode in ID is
//   decoded into EX/M/WB control bundles. Each bundle then travels through the
//   ID/EX, EX/MEM and MEM/WB control registers, so it stays aligned with its
//   instruction. Stalls and flushes insert bubbles. Unknown opcodes are flagged
//   and counted.
//
// Parameters
//   ALUOP_W  ALUOp width. Must be >= 2, and >= 3 when EXT_OPS=1. The 3-bit
//            ALUOp code is resized to this width.
//   EXT_OPS  1 enables decoding of andi/ori/slti.
//   CNT_W    width of the saturating illegal-opcode counter.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   op             opcode of the instruction in ID
//   id_valid       ID holds a real instruction
//   stall          load-use hazard: ID/EX loads a bubble
//   flush          taken branch: ID/EX and EX/MEM load bubbles
//   clr_cnt        synchronous clear of illegal_cnt (wins over an increment)
//   ex_ctl         ID/EX   {RegDst, ALUOp, ALUSrc}
//   m_ctl          EX/MEM  {Branch, MemRead, MemWrite}
//   wb_ctl         MEM/WB  {RegWrite, MemtoReg}
//   memread_ex     MemRead held in ID/EX (hazard unit)
//   regwrite_mem   RegWrite held in EX/MEM (forwarding)
//   illegal_op     registered with ID/EX: the decoded opcode was unknown
//   illegal_cnt    saturating count of illegal opcodes loaded into ID/EX
module control_pipe #(
  parameter int ALUOP_W = 2,
  parameter int EXT_OPS = 0,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic                 id_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 clr_cnt,
  output logic [ALUOP_W+1:0]   ex_ctl,
  output logic [2:0]           m_ctl,
  output logic [1:0]           wb_ctl,
  output logic                 memread_ex,
  output logic                 regwrite_mem,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     illegal_cnt
);

  logic       reg_dst, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg;
  logic [2:0] aluop3;
  logic       illegal;

  always_comb begin
    reg_dst    = 1'b0;
    aluop3     = 3'b000;
    alu_src    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (op)
      6'b000000: begin reg_dst = 1'b1; aluop3 = 3'b010; reg_write = 1'b1; end
      6'b100011: begin
        alu_src = 1'b1; mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
      end
      6'b101011: begin alu_src = 1'b1; mem_write = 1'b1; end
      6'b000100: begin aluop3 = 3'b001; branch = 1'b1; end
      6'b001000: begin alu_src = 1'b1; reg_write = 1'b1; end
      6'b001100: begin
        if (EXT_OPS != 0) begin aluop3 = 3'b011; alu_src = 1'b1; reg_write = 1'b1; end
        else illegal = 1'b1;
      end
      6'b001101: begin
        if (EXT_OPS != 0) begin aluop3 = 3'b100; alu_src = 1'b1; reg_write = 1'b1; end
        else illegal = 1'b1;
      end
      6'b001010: begin
        if (EXT_OPS != 0) begin aluop3 = 3'b101; alu_src = 1'b1; reg_write = 1'b1; end
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // A bubble wins over the decoded bundle; illegal_op is cleared with it so a
  // stalled or flushed illegal opcode is counted only once, when it finally loads.
  logic bubble_id;
  logic ill_load;
  assign bubble_id = !id_valid || stall || flush;
  assign ill_load  = !bubble_id && illegal;

  logic [2:0] idex_m;
  logic [1:0] idex_wb;
  logic [1:0] exmem_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctl     <= '0;
      idex_m     <= '0;
      idex_wb    <= '0;
      illegal_op <= 1'b0;
    end else if (bubble_id) begin
      ex_ctl     <= '0;
      idex_m     <= '0;
      idex_wb    <= '0;
      illegal_op <= 1'b0;
    end else begin
      ex_ctl     <= {reg_dst, ALUOP_W'(aluop3), alu_src};
      idex_m     <= {branch, mem_read, mem_write};
      idex_wb    <= {reg_write, mem_to_reg};
      illegal_op <= illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctl    <= '0;
      exmem_wb <= '0;
    end else if (flush) begin
      m_ctl    <= '0;
      exmem_wb <= '0;
    end else begin
      m_ctl    <= idex_m;
      exmem_wb <= idex_wb;
    end
  end

  // MEM/WB is never flushed: the instruction ahead of a taken branch retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_ctl <= '0;
    else        wb_ctl <= exmem_wb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               illegal_cnt <= '0;
    else if (clr_cnt)                         illegal_cnt <= '0;
    else if (ill_load && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + 1'b1;
  end

  assign memread_ex   = idex_m[1];
  assign regwrite_mem = exmem_wb[1];

endmodule

// File: tb/tb_control_pipe.sv
module tb_control_pipe;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // dut0: ALUOP_W=2, EXT_OPS=0, CNT_W=2
  logic [5:0] op0 = '0;
  logic v0 = 0, st0 = 0, fl0 = 0, clr0 = 0;
  logic [3:0] ex0;
  logic [2:0] m0;
  logic [1:0] wb0;
  logic mr0, rw0, ill0;
  logic [1:0] cnt0;

  // dut1: ALUOP_W=3, EXT_OPS=1, CNT_W=8
  logic [5:0] op1 = '0;
  logic v1 = 0, st1 = 0, fl1 = 0, clr1 = 0;
  logic [4:0] ex1;
  logic [2:0] m1;
  logic [1:0] wb1;
  logic mr1, rw1, ill1;
  logic [7:0] cnt1;

  control_pipe #(.ALUOP_W(2), .EXT_OPS(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .op(op0), .id_valid(v0), .stall(st0), .flush(fl0),
    .clr_cnt(clr0), .ex_ctl(ex0), .m_ctl(m0), .wb_ctl(wb0), .memread_ex(mr0),
    .regwrite_mem(rw0), .illegal_op(ill0), .illegal_cnt(cnt0));

  control_pipe #(.ALUOP_W(3), .EXT_OPS(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .op(op1), .id_valid(v1), .stall(st1), .flush(fl1),
    .clr_cnt(clr1), .ex_ctl(ex1), .m_ctl(m1), .wb_ctl(wb1), .memread_ex(mr1),
    .regwrite_mem(rw1), .illegal_op(ill1), .illegal_cnt(cnt1));

  typedef struct {
    int         row;
    bit         sel;
    logic [4:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic       ill;
    logic [7:0] cnt;
    logic       mr;
    logic       rw;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int row_id = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus into the selected DUT (the other idles) and
  // queue the hand-computed outputs expected right after the next rising edge.
  task automatic step(input bit sel, input logic [5:0] op, input logic v,
                      input logic st, input logic fl, input logic clr,
                      input logic [4:0] ex, input logic [2:0] m, input logic [1:0] wb,
                      input logic ill, input logic [7:0] cnt, input logic mr,
                      input logic rw);
    exp_t e;
    @(negedge clk);
    row_id++;
    op0 = sel ? 6'd0 : op; v0 = sel ? 1'b0 : v; st0 = sel ? 1'b0 : st;
    fl0 = sel ? 1'b0 : fl; clr0 = sel ? 1'b0 : clr;
    op1 = sel ? op : 6'd0; v1 = sel ? v : 1'b0; st1 = sel ? st : 1'b0;
    fl1 = sel ? fl : 1'b0; clr1 = sel ? clr : 1'b0;
    e.row = row_id; e.sel = sel; e.ex = ex; e.m = m; e.wb = wb;
    e.ill = ill; e.cnt = cnt; e.mr = mr; e.rw = rw;
    sb.push_back(e);
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.sel) begin
          chk($sformatf("row%0d ex_ctl", e.row), int'(ex1), int'(e.ex));
          chk($sformatf("row%0d m_ctl", e.row), int'(m1), int'(e.m));
          chk($sformatf("row%0d wb_ctl", e.row), int'(wb1), int'(e.wb));
          chk($sformatf("row%0d illegal_op", e.row), int'(ill1), int'(e.ill));
          chk($sformatf("row%0d illegal_cnt", e.row), int'(cnt1), int'(e.cnt));
          chk($sformatf("row%0d memread_ex", e.row), int'(mr1), int'(e.mr));
          chk($sformatf("row%0d regwrite_mem", e.row), int'(rw1), int'(e.rw));
        end else begin
          chk($sformatf("row%0d ex_ctl", e.row), int'(ex0), int'(e.ex));
          chk($sformatf("row%0d m_ctl", e.row), int'(m0), int'(e.m));
          chk($sformatf("row%0d wb_ctl", e.row), int'(wb0), int'(e.wb));
          chk($sformatf("row%0d illegal_op", e.row), int'(ill0), int'(e.ill));
          chk($sformatf("row%0d illegal_cnt", e.row), int'(cnt0), int'(e.cnt));
          chk($sformatf("row%0d memread_ex", e.row), int'(mr0), int'(e.mr));
          chk($sformatf("row%0d regwrite_mem", e.row), int'(rw0), int'(e.rw));
        end
      end
    end
  end

  task automatic chk_dut0_zero(input string tag);
    chk({tag, " ex_ctl"}, int'(ex0), 0);
    chk({tag, " m_ctl"}, int'(m0), 0);
    chk({tag, " wb_ctl"}, int'(wb0), 0);
    chk({tag, " illegal_op"}, int'(ill0), 0);
    chk({tag, " illegal_cnt"}, int'(cnt0), 0);
    chk({tag, " memread_ex"}, int'(mr0), 0);
    chk({tag, " regwrite_mem"}, int'(rw0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk_dut0_zero("reset");
    chk("reset dut1 ex_ctl", int'(ex1), 0);
    chk("reset dut1 illegal_cnt", int'(cnt1), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pipeline alignment: lw, sw, R-type back to back.
    step(0, OP_LW,   1, 0, 0, 0, 5'b0001, 3'b000, 2'b00, 0, 0, 1, 0);
    step(0, OP_SW,   1, 0, 0, 0, 5'b0001, 3'b010, 2'b00, 0, 0, 0, 1);
    step(0, OP_R,    1, 0, 0, 0, 5'b1100, 3'b001, 2'b11, 0, 0, 0, 0);
    step(0, OP_R,    0, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 0, 0, 0, 1);
    step(0, OP_R,    0, 0, 0, 0, 5'b0000, 3'b000, 2'b10, 0, 0, 0, 0);
    step(0, OP_R,    0, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 0, 0, 0, 0);
    // Load-use stall: one bubble, then the R-type is decoded again.
    step(0, OP_LW,   1, 0, 0, 0, 5'b0001, 3'b000, 2'b00, 0, 0, 1, 0);
    step(0, OP_R,    1, 1, 0, 0, 5'b0000, 3'b010, 2'b00, 0, 0, 0, 1);
    step(0, OP_R,    1, 0, 0, 0, 5'b1100, 3'b000, 2'b11, 0, 0, 0, 0);
    step(0, OP_R,    0, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 0, 0, 0, 1);
    step(0, OP_R,    0, 0, 0, 0, 5'b0000, 3'b000, 2'b10, 0, 0, 0, 0);
    // Flush while beq is in EX: lw ahead of it still retires wb=11.
    step(0, OP_LW,   1, 0, 0, 0, 5'b0001, 3'b000, 2'b00, 0, 0, 1, 0);
    step(0, OP_BEQ,  1, 0, 0, 0, 5'b0010, 3'b010, 2'b00, 0, 0, 0, 1);
    step(0, OP_ADDI, 1, 0, 1, 0, 5'b0000, 3'b000, 2'b11, 0, 0, 0, 0);
    step(0, OP_R,    0, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 0, 0, 0, 0);
    // Stall and flush together: single bubble, sw in ID/EX is dropped from EX/MEM.
    step(0, OP_SW,   1, 0, 0, 0, 5'b0001, 3'b000, 2'b00, 0, 0, 0, 0);
    step(0, OP_R,    1, 1, 1, 0, 5'b0000, 3'b000, 2'b00, 0, 0, 0, 0);
    step(0, OP_R,    0, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 0, 0, 0, 0);
    // Illegal andi with EXT_OPS=0, 2-bit counter saturating at 3.
    step(0, OP_ANDI, 1, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 1, 1, 0, 0);
    step(0, OP_ANDI, 1, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 1, 2, 0, 0);
    step(0, OP_ANDI, 1, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 1, 3, 0, 0);
    step(0, OP_ANDI, 1, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 1, 3, 0, 0);
    step(0, OP_ANDI, 1, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 1, 3, 0, 0);
    step(0, OP_ANDI, 1, 0, 0, 1, 5'b0000, 3'b000, 2'b00, 1, 0, 0, 0);
    step(0, OP_ANDI, 1, 1, 0, 0, 5'b0000, 3'b000, 2'b00, 0, 0, 0, 0);
    step(0, OP_ANDI, 1, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 1, 1, 0, 0);
    step(0, OP_R,    0, 0, 0, 1, 5'b0000, 3'b000, 2'b00, 0, 0, 0, 0);
    step(0, 6'b111111, 1, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 1, 1, 0, 0);
    step(0, OP_R,    0, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 0, 1, 0, 0);
    step(0, OP_LW,   1, 0, 0, 0, 5'b0001, 3'b000, 2'b00, 0, 1, 1, 0);

    // Mid-stream asynchronous reset with nonzero outputs, away from any edge.
    @(posedge clk);
    #3;
    op0 = '0; v0 = 0;
    rst_n = 1'b0;
    #1;
    chk_dut0_zero("async reset");
    @(posedge clk);
    #1;
    chk_dut0_zero("reset held");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, OP_R,    0, 0, 0, 0, 5'b0000, 3'b000, 2'b00, 0, 0, 0, 0);

    // Extended ops, ALUOP_W=3.
    step(1, OP_ORI,  1, 0, 0, 0, 5'b01001, 3'b000, 2'b00, 0, 0, 0, 0);
    step(1, OP_ANDI, 1, 0, 0, 0, 5'b00111, 3'b000, 2'b00, 0, 0, 0, 1);
    step(1, OP_SLTI, 1, 0, 0, 0, 5'b01011, 3'b000, 2'b10, 0, 0, 0, 1);
    step(1, OP_R,    1, 0, 0, 0, 5'b10100, 3'b000, 2'b10, 0, 0, 0, 1);
    step(1, OP_LW,   1, 0, 0, 0, 5'b00001, 3'b000, 2'b10, 0, 0, 1, 1);
    step(1, OP_BEQ,  1, 0, 0, 0, 5'b00010, 3'b010, 2'b10, 0, 0, 0, 1);
    step(1, OP_R,    0, 0, 0, 0, 5'b00000, 3'b100, 2'b11, 0, 0, 0, 0);
    step(1, 6'b111110, 1, 0, 0, 0, 5'b00000, 3'b000, 2'b00, 1, 1, 0, 0);

    @(negedge clk);
    v1 = 0; op1 = '0;
    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
# control_pipe

Pipelined main control unit for the MIPS datapath. It decodes the 6-bit opcode in ID into the EX/M/WB control bundles. The bundles are carried through the ID/EX, EX/MEM and MEM/WB control registers, so each stage receives its controls aligned with its instruction. Load-use stalls and branch flushes insert bubbles, and illegal opcodes are flagged and counted.

## Interface
Parameters:
- ALUOP_W, 2, ALUOp field width; must be ≥2, and ≥3 when EXT_OPS=1
- EXT_OPS, 0, 1 enables decoding of andi/ori/slti
- CNT_W, 8, illegal-opcode counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  opcode of the instruction in ID
- id_valid  in  1  ID holds a real instruction
- stall  in  1  load-use hazard; turns the ID/EX load into a bubble
- flush  in  1  branch taken; turns the ID/EX and EX/MEM loads into bubbles
- clr_cnt  in  1  synchronous clear of illegal_cnt
- ex_ctl  out  ALUOP_W+2  ID/EX register {RegDst, ALUOp, ALUSrc}
- m_ctl  out  3  EX/MEM register {Branch, MemRead, MemWrite}
- wb_ctl  out  2  MEM/WB register {RegWrite, MemtoReg}
- memread_ex  out  1  MemRead held in ID/EX, for the hazard unit
- regwrite_mem  out  1  RegWrite held in EX/MEM, for forwarding
- illegal_op  out  1  registered with ID/EX; the decoded opcode was unknown
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes

## Operation
Decode table, given as RegDst/ALUOp/ALUSrc, Branch/MemRead/MemWrite, RegWrite/MemtoReg. ALUOp is shown in 3-bit form; when ALUOP_W is wider, ALUOp is zero-extended.
- R-type 000000: 1/010/0, 000, 10
- lw 100011: 0/000/1, 010, 11
- sw 101011: 0/000/1, 001, 00
- beq 000100: 0/001/0, 100, 00
- addi 001000: 0/000/1, 000, 10
- EXT_OPS=1 only:
  - andi 001100: 0/011/1, 000, 10
  - ori 001101: 0/100/1, 000, 10
  - slti 001010: 0/101/1, 000, 10
- Any other opcode (including andi/ori/slti when EXT_OPS=0) decodes to all-zero controls and is marked illegal.

ID/EX register, loaded every cycle:
- A bubble (all zeros, illegal_op=0) is loaded when id_valid=0, stall=1 or flush=1.
- Otherwise the register loads the decoded EX, M and WB fields plus the illegal flag.

EX/MEM register:
- When flush=1, it loads zeros.
- Otherwise it loads the M and WB fields from ID/EX.

MEM/WB register:
- Always loads the WB field from EX/MEM; it is never flushed.

illegal_cnt:
- Increments on each cycle in which the ID/EX register loads illegal=1.
- Saturates at 2^CNT_W−1.
- clr_cnt=1 forces 0 on the next edge and overrides a simultaneous increment.

Simultaneous stall and flush produce one bubble; flush takes precedence for EX/MEM.

## Timing
- Reset (asynchronous, rst_n=0): every output register, illegal_op and illegal_cnt are 0 immediately and stay 0 until the first rising edge after rst_n rises.
- Reset mid-instruction discards all in-flight controls; nothing resumes after reset.
- Latency for an op sampled at edge k:
  - ex_ctl, memread_ex and illegal_op are valid after edge k.
  - m_ctl and regwrite_mem are valid after edge k+1.
  - wb_ctl is valid after edge k+2.
- There is no combinational path from any input to any output.
- Stall does not hold ID/EX. The upstream IF/ID register keeps op stable, and the instruction is decoded again on the following cycle.
- Throughput is one decode per cycle.

## Test plan
- Reset: hold rst_n=0 mid-stream with outputs nonzero → all outputs go to 0 without a clock edge.
- Pipeline alignment: issue lw, then sw, then R-type on consecutive cycles.
  - After lw's edge: ex_ctl=0_00_1 (ALUOP_W=2).
  - One edge later: m_ctl=010.
  - One edge after that: wb_ctl=11 while m_ctl=001.
- Stall: issue lw, then R-type with stall=1 for one cycle.
  - The ID/EX register holds zeros for exactly one cycle.
  - The R-type appears the next cycle with ex_ctl=1_10_0.
- Flush: flush=1 while beq is in EX.
  - The next ID/EX and EX/MEM loads are zero.
  - wb_ctl of the older instruction still retires unchanged.
- Illegal opcodes, CNT_W=2, EX_OPS=0: issue andi five times.
  - illegal_op=1 each time.
  - illegal_cnt goes 1, 2, 3, 3, 3.
  - clr_cnt together with a sixth andi gives illegal_cnt=0.
- EXT_OPS=1, ALUOP_W=3: issue ori → ex_ctl=0_100_1, wb_ctl=10, illegal_op=0.
